alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 29 ++
 rtl/seq_muldiv.sv | 79 +++++++
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, sequencer state encoding and default
//               datapath widths for the sequential ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default widths: result is twice the operand width so mul fits.
    localparam int OPW_DEFAULT  = 3;
    localparam int RESW_DEFAULT = 2 * OPW_DEFAULT;

    // Opcode encoding; bit 1 set selects the iterative (mul/div) datapath.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv
// Description : Iterative unsigned multiply (shift-add, LSB first) and
//               restoring divide (MSB first), one bit per step. The partial
//               output is the value the datapath will hold once the step in
//               progress completes, so the controller can capture the final
//               answer on the same edge as the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int OPW  = OPW_DEFAULT,
    parameter int RESW = 2 * OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  op_a,
    input  logic [OPW-1:0]  op_b,
    input  logic            div_mode,
    input  logic            clear,
    input  logic            step,
    output logic [RESW-1:0] partial
);

    // Multiply state: accumulator, shifted multiplicand, consumed multiplier.
    logic [RESW-1:0] r_acc;
    logic [RESW-1:0] r_mcand;
    logic [OPW-1:0]  r_mplier;
    // Divide state: running remainder and dividend/quotient shift register.
    logic [OPW-1:0]  r_rem;
    logic [OPW-1:0]  r_quo;

    logic [RESW-1:0] w_acc_nxt;
    logic [OPW:0]    w_rem_sh;
    logic            w_fits;
    logic [OPW-1:0]  w_rem_nxt;
    logic [OPW-1:0]  w_quo_nxt;

    // Next-step values for both algorithms.
    always_comb begin
        w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        // Bring down the next dividend bit; one extra bit avoids overflow.
        w_rem_sh  = {r_rem, r_quo[OPW-1]};
        w_fits    = (w_rem_sh >= {1'b0, op_b});
        w_rem_nxt = w_fits ? OPW'(w_rem_sh - {1'b0, op_b}) : w_rem_sh[OPW-1:0];
        w_quo_nxt = {r_quo[OPW-2:0], w_fits};
        partial   = div_mode ? RESW'({w_rem_nxt, w_quo_nxt}) : w_acc_nxt;
    end

    // Load operands on clear, advance one bit per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
        end else if (clear) begin
            r_acc    <= '0;
            r_mcand  <= RESW'(op_a);
            r_mplier <= op_b;
            r_rem    <= '0;
            r_quo    <= op_a;
        end else if (step) begin
            if (div_mode) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

endmodule : seq_muldiv
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequenced unsigned ALU. Accepts one operation per start in
//               IDLE, runs LOAD -> EXEC -> DONE and pulses done one cycle
//               after DONE. Add/sub are single-cycle here; mul/div step the
//               seq_muldiv datapath for OPW cycles. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int OPW  = OPW_DEFAULT,
    parameter int RESW = 2 * OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  portA,
    input  logic [OPW-1:0]  portB,
    input  logic [1:0]      opcode,
    output logic            busy,
    output logic            done,
    output logic [RESW-1:0] result,
    output logic            signo,
    output logic            err
);

    localparam int                c_cnt_w    = (OPW > 1) ? $clog2(OPW) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OPW - 1);

    state_t             r_state;
    logic [OPW-1:0]     r_a;
    logic [OPW-1:0]     r_b;
    logic [1:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [RESW-1:0]    r_result;
    logic               r_signo;
    logic               r_err;
    logic               r_busy;
    logic               r_done;

    logic [RESW-1:0]    w_sum;
    logic [RESW-1:0]    w_absdiff;
    logic               w_a_lt_b;
    logic [RESW-1:0]    w_md_partial;
    logic               w_md_clear;
    logic               w_md_step;

    // Single-cycle add/sub datapath and mul/div stepping controls.
    always_comb begin
        w_a_lt_b   = (r_a < r_b);
        w_sum      = RESW'(r_a) + RESW'(r_b);
        w_absdiff  = w_a_lt_b ? RESW'(r_b - r_a) : RESW'(r_a - r_b);
        w_md_clear = (r_state == ST_LOAD);
        w_md_step  = (r_state == ST_EXEC) && r_op[1];
    end

    seq_muldiv #(
        .OPW  (OPW),
        .RESW (RESW)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .op_a     (r_a),
        .op_b     (r_b),
        .div_mode (r_op == OP_DIV),
        .clear    (w_md_clear),
        .step     (w_md_step),
        .partial  (w_md_partial)
    );

    // Sequencer with registered status/result; outputs change only at the
    // end of an operation so they stay stable while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_result <= '0;
            r_signo  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= portA;
                        r_b     <= portB;
                        r_op    <= opcode;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt <= '0;
                    // Divide by zero short-circuits straight to DONE.
                    if ((r_op == OP_DIV) && (r_b == '0)) begin
                        r_result <= '0;
                        r_signo  <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!r_op[1]) begin
                        r_result <= (r_op == OP_SUB) ? w_absdiff : w_sum;
                        r_signo  <= (r_op == OP_SUB) && w_a_lt_b;
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_result <= w_md_partial;
                        r_signo  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign signo  = r_signo;
    assign err    = r_err;

endmodule : alu_seq_ctrl
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl: directed cases with
//               literal expectations plus randomized traffic compared every
//               cycle against a latency/arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int OPW  = 3;
    localparam int RESW = 6;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic [OPW-1:0]  portA = '0;
    logic [OPW-1:0]  portB = '0;
    logic [1:0]      opcode = 2'b00;
    logic            busy;
    logic            done;
    logic [RESW-1:0] result;
    logic            signo;
    logic            err;

    alu_seq_ctrl #(.OPW(OPW), .RESW(RESW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .portA  (portA),
        .portB  (portB),
        .opcode (opcode),
        .busy   (busy),
        .done   (done),
        .result (result),
        .signo  (signo),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: an accepted start schedules a done pulse L edges later,
    // busy covers the edges in between, results are plain arithmetic.
    int m_cnt   = 0;
    int m_done  = 0;
    int m_res   = 0;
    int m_signo = 0;
    int m_err   = 0;
    int p_res, p_signo, p_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_done = 0; m_res = 0; m_signo = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (start === 1'b1) begin
                    int a, b;
                    a = int'(portA);
                    b = int'(portB);
                    p_signo = 0;
                    p_err   = 0;
                    case (opcode)
                        2'd0: begin p_res = a + b; m_cnt = 3; end
                        2'd1: begin
                            p_res   = (a >= b) ? a - b : b - a;
                            p_signo = (a < b) ? 1 : 0;
                            m_cnt   = 3;
                        end
                        2'd2: begin p_res = a * b; m_cnt = OPW + 2; end
                        default: begin
                            if (b == 0) begin
                                p_res = 0; p_err = 1; m_cnt = 2;
                            end else begin
                                p_res = ((a % b) << OPW) + (a / b);
                                m_cnt = OPW + 2;
                            end
                        end
                    endcase
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1; m_res = p_res; m_signo = p_signo; m_err = p_err;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_cnt != 0));
        check("done", 32'(done), 32'(m_done));
        if (m_cnt == 0) begin
            check("result", 32'(result), 32'(m_res));
            check("signo", 32'(signo), 32'(m_signo));
            check("err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic run_op(input int a, input int b, input int op, input int e_res,
                          input int e_sg, input int e_err, input int e_lat, input string nm);
        int t0, lat;
        @(negedge clk);
        portA = OPW'(a); portB = OPW'(b); opcode = 2'(op); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        wait_done(t0, lat);
        check({nm, " latency"}, 32'(lat), 32'(e_lat));
        check({nm, " result"}, 32'(result), 32'(e_res));
        check({nm, " signo"}, 32'(signo), 32'(e_sg));
        check({nm, " err"}, 32'(err), 32'(e_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, lat, saw, n;
        int dt[3];
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset signo", 32'(signo), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk) rst = 1'b1;

        run_op(3, 4, 0, 7, 0, 0, 3, "add 3+4");
        run_op(2, 5, 1, 3, 1, 0, 3, "sub 2-5");
        run_op(5, 5, 1, 0, 0, 0, 3, "sub 5-5");
        run_op(7, 7, 2, 49, 0, 0, 5, "mul 7*7");
        run_op(0, 6, 2, 0, 0, 0, 5, "mul 0*6");
        run_op(7, 2, 3, 11, 0, 0, 5, "div 7/2");
        run_op(5, 0, 3, 0, 0, 1, 2, "div 5/0");

        // Inputs and start changed while EXEC runs must be ignored.
        @(negedge clk);
        portA = 3'd7; portB = 3'd7; opcode = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        @(posedge clk);
        #1 portA = 3'd1; portB = 3'd1; opcode = 2'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t0, lat);
        check("busy-ignore latency", 32'(lat), 32'd5);
        check("busy-ignore result", 32'(result), 32'd49);

        // Asynchronous reset in the second EXEC cycle aborts the operation.
        @(negedge clk);
        portA = 3'd3; portB = 3'd3; opcode = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort signo", 32'(signo), 32'd0);
        check("abort err", 32'(err), 32'd0);
        @(negedge clk) rst = 1'b1;
        saw = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw++;
        end
        check("no done after abort", 32'(saw), 32'd0);
        run_op(3, 4, 0, 7, 0, 0, 3, "add after abort");

        // start held high: back-to-back adds every 4 cycles.
        @(negedge clk);
        portA = 3'd1; portB = 3'd1; opcode = 2'd0; start = 1'b1;
        n = 0;
        dt = '{0, 0, 0};
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dt[n] = cyc;
                check("b2b result", 32'(result), 32'd2);
                n++;
            end
        end
        check("b2b count", 32'(n), 32'd3);
        check("b2b gap1", 32'(dt[1] - dt[0]), 32'd4);
        check("b2b gap2", 32'(dt[2] - dt[1]), 32'd4);
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);

        // Randomized traffic, including changes while busy and resets.
        repeat (600) begin
            @(negedge clk);
            start  = ($urandom_range(0, 2) != 0);
            portA  = OPW'($urandom_range(0, 7));
            portB  = OPW'($urandom_range(0, 7));
            opcode = 2'($urandom_range(0, 3));
            if (rst == 1'b0) begin
                #2 rst = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq_ctrl
`default_nettype wire
